dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Single-outstanding data-memory responder with byte/half/word
//             loads and stores, including misaligned accesses that straddle
//             two storage words. Out-of-window or illegal-size requests are
//             rejected with an error response and no memory side effect.
//  Ports    : i_clk, i_reset_n (async, active-low)
//             request  : i_req_valid / o_req_ready, i_req_addr, i_req_wdata,
//                        i_req_size, i_req_wren, i_req_signed
//             response : o_rsp_valid / i_rsp_ready, o_rsp_rdata, o_rsp_err
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 512
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_wren,
    input  logic        i_req_signed,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int          AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] C_ADDR_LAST = 33'(4 * DEPTH_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t         state_q,  state_d;
    logic [AW-1:0]  widx_q,   widx_d;
    logic [1:0]     offset_q, offset_d;
    logic [2:0]     nbytes_q, nbytes_d;
    logic           wren_q,   wren_d;
    logic           signed_q, signed_d;
    logic [31:0]    wdata_q,  wdata_d;
    logic [31:0]    lo_q,     lo_d;
    logic [31:0]    rdata_q,  rdata_d;
    logic           err_q,    err_d;

    logic [31:0]    mem_q [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Request decode (used only at the accept edge)
    // ------------------------------------------------------------------
    logic [2:0]     w_req_nbytes;
    logic [32:0]    w_req_last;
    logic           w_req_err;

    always_comb begin
        case (i_req_size)
            2'b00:   w_req_nbytes = 3'd1;
            2'b01:   w_req_nbytes = 3'd2;
            default: w_req_nbytes = 3'd4;
        endcase
    end

    // 33-bit sum so an access near 0xFFFF_FFFF cannot wrap into the window.
    assign w_req_last = {1'b0, i_req_addr} + {30'd0, w_req_nbytes} - 33'd1;
    assign w_req_err  = (i_req_size == 2'b11) || (w_req_last > C_ADDR_LAST);

    // ------------------------------------------------------------------
    // Access datapath. One storage word is touched per access cycle:
    // W in ACC0, W+1 in ACC1. The pair {W+1, W} is treated as 8 byte lanes.
    // ------------------------------------------------------------------
    logic           w_span;
    logic [AW-1:0]  w_acc_idx;
    logic [31:0]    w_rd_word;
    logic [63:0]    w_pair;
    logic [31:0]    w_shift;
    logic [31:0]    w_load;
    logic [7:0]     w_st_be;
    logic [63:0]    w_st_data;
    logic           w_mem_we;
    logic [3:0]     w_lane_be;
    logic [31:0]    w_lane_data;

    assign w_span    = ({1'b0, offset_q} + nbytes_q) > 3'd4;
    assign w_acc_idx = (state_q == ACC1) ? (widx_q + AW'(1)) : widx_q;
    assign w_rd_word = mem_q[w_acc_idx];

    // In ACC1 the low word was captured in lo_q during ACC0.
    assign w_pair  = (state_q == ACC1) ? {w_rd_word, lo_q} : {32'd0, w_rd_word};
    assign w_shift = 32'(w_pair >> {offset_q, 3'b000});

    always_comb begin
        case (nbytes_q)
            3'd1:    w_load = {{24{signed_q & w_shift[7]}},  w_shift[7:0]};
            3'd2:    w_load = {{16{signed_q & w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_comb begin
        case (nbytes_q)
            3'd1:    w_st_be = 8'b0000_0001;
            3'd2:    w_st_be = 8'b0000_0011;
            default: w_st_be = 8'b0000_1111;
        endcase
        w_st_be = w_st_be << offset_q;
    end

    assign w_st_data   = {32'd0, wdata_q} << {offset_q, 3'b000};
    assign w_mem_we    = wren_q && ((state_q == ACC0) || (state_q == ACC1));
    assign w_lane_be   = (state_q == ACC1) ? w_st_be[7:4]    : w_st_be[3:0];
    assign w_lane_data = (state_q == ACC1) ? w_st_data[63:32] : w_st_data[31:0];

    // Storage is deliberately outside the reset domain: contents survive reset,
    // and a reset after ACC0 of a spanning store leaves only word W updated.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lane_be[b]) begin
                    mem_q[w_acc_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next-state and register next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        offset_d = offset_q;
        nbytes_d = nbytes_q;
        wren_d   = wren_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    widx_d   = i_req_addr[AW+1:2];
                    offset_d = i_req_addr[1:0];
                    nbytes_d = w_req_nbytes;
                    wren_d   = i_req_wren;
                    signed_d = i_req_signed;
                    wdata_d  = i_req_wdata;
                    rdata_d  = 32'd0;
                    err_d    = w_req_err;
                    state_d  = w_req_err ? RESP : ACC0;
                end
            end
            ACC0: begin
                lo_d = w_rd_word;
                if (w_span) begin
                    state_d = ACC1;
                end else begin
                    state_d = RESP;
                    rdata_d = wren_q ? 32'd0 : w_load;
                end
            end
            ACC1: begin
                state_d = RESP;
                rdata_d = wren_q ? 32'd0 : w_load;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            widx_q   <= '0;
            offset_q <= 2'd0;
            nbytes_q <= 3'd0;
            wren_q   <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= 32'd0;
            lo_q     <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            widx_q   <= widx_d;
            offset_q <= offset_d;
            nbytes_q <= nbytes_d;
            wren_q   <= wren_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_rsp_valid = (state_q == RESP);
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Directed self-checking bench for dmem_responder (DEPTH 512).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [1:0]  i_req_size;
    logic        i_req_wren;
    logic        i_req_signed;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

    dmem_responder #(.DEPTH_WORDS(512)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .i_req_size   (i_req_size),
        .i_req_wren   (i_req_wren),
        .i_req_signed (i_req_signed),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, return the first response cycle's data and latency.
    task automatic send(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                        input logic wr, input logic sg,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        i_req_valid  = 1'b1;
        i_req_addr   = a;
        i_req_wdata  = wd;
        i_req_size   = sz;
        i_req_wren   = wr;
        i_req_signed = sg;
        n = 0;
        while (!o_req_ready && n < 20) begin
            @(posedge i_clk); #1;
            n++;
        end
        @(posedge i_clk); #1;
        // Scramble the bus so unlatched use of request fields shows up.
        i_req_valid  = 1'b0;
        i_req_addr   = ~a;
        i_req_wdata  = ~wd;
        i_req_size   = ~sz;
        i_req_wren   = ~wr;
        i_req_signed = ~sg;
        lat = 1;
        while (!o_rsp_valid && lat < 20) begin
            @(posedge i_clk); #1;
            lat++;
        end
        chk("rsp_seen", {31'd0, o_rsp_valid}, 32'd1);
        rd = o_rsp_rdata;
        er = o_rsp_err;
    endtask

    task automatic tx(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic wr, input logic sg,
                      input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        send(a, wd, sz, wr, sg, rd, er, lat);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_er});
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [31:0] held;

        i_reset_n    = 1'b0;
        i_req_valid  = 1'b0;
        i_req_addr   = 32'd0;
        i_req_wdata  = 32'd0;
        i_req_size   = SZ_W;
        i_req_wren   = 1'b0;
        i_req_signed = 1'b0;
        i_rsp_ready  = 1'b1;

        // Reset takes effect before any clock edge.
        #2;
        chk("rst.valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst.rdata", o_rsp_rdata, 32'd0);
        chk("rst.err",   {31'd0, o_rsp_err}, 32'd0);
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        chk("rst.ready", {31'd0, o_req_ready}, 32'd1);

        // Aligned word store/load
        tx("st_w10",  32'h10, 32'h11223344, SZ_W, 1, 0, 32'h0,        0, 2);
        tx("ld_w10",  32'h10, 32'h0,        SZ_W, 0, 0, 32'h11223344, 0, 2);

        // Misaligned word spanning 0x20/0x24
        tx("pre_w20", 32'h20, 32'h55667788, SZ_W, 1, 0, 32'h0, 0, 2);
        tx("pre_w24", 32'h24, 32'h99AABBCC, SZ_W, 1, 0, 32'h0, 0, 2);
        tx("st_w21",  32'h21, 32'hAABBCCDD, SZ_W, 1, 0, 32'h0,        0, 3);
        tx("ld_w21",  32'h21, 32'h0,        SZ_W, 0, 0, 32'hAABBCCDD, 0, 3);
        tx("ld_bu20", 32'h20, 32'h0,        SZ_B, 0, 0, 32'h00000088, 0, 2);
        tx("ld_w24",  32'h24, 32'h0,        SZ_W, 0, 0, 32'h99AABBAA, 0, 2);
        tx("ld_w20",  32'h20, 32'h0,        SZ_W, 0, 0, 32'hBBCCDD88, 0, 2);

        // Half at offset 3 spans 0x30/0x34
        tx("pre_w30", 32'h30, 32'h0, SZ_W, 1, 0, 32'h0, 0, 2);
        tx("pre_w34", 32'h34, 32'h0, SZ_W, 1, 0, 32'h0, 0, 2);
        tx("st_h33",  32'h33, 32'h000080FF, SZ_H, 1, 0, 32'h0,        0, 3);
        tx("ld_hs33", 32'h33, 32'h0,        SZ_H, 0, 1, 32'hFFFF80FF, 0, 3);
        tx("ld_hu33", 32'h33, 32'h0,        SZ_H, 0, 0, 32'h000080FF, 0, 3);
        tx("ld_bs33", 32'h33, 32'h0,        SZ_B, 0, 1, 32'hFFFFFFFF, 0, 2);
        tx("ld_bs34", 32'h34, 32'h0,        SZ_B, 0, 1, 32'hFFFFFF80, 0, 2);
        tx("ld_bu34", 32'h34, 32'h0,        SZ_B, 0, 0, 32'h00000080, 0, 2);
        tx("ld_hs32", 32'h32, 32'h0,        SZ_H, 0, 1, 32'hFFFFFF00, 0, 2);
        tx("ld_w30",  32'h30, 32'h0,        SZ_W, 0, 0, 32'hFF000000, 0, 2);
        tx("ld_ws34", 32'h34, 32'h0,        SZ_W, 0, 1, 32'h00000080, 0, 2);

        // Byte store touches one lane only; signed flag ignored for words
        tx("st_b11",  32'h11, 32'hFFFFFF5A, SZ_B, 1, 0, 32'h0,        0, 2);
        tx("ld_ws10", 32'h10, 32'h0,        SZ_W, 0, 1, 32'h11225A44, 0, 2);
        tx("ld_hs12", 32'h12, 32'h0,        SZ_H, 0, 1, 32'h00001122, 0, 2);

        // Window edge and illegal requests
        tx("st_w7fc", 32'h7FC, 32'h01020304, SZ_W, 1, 0, 32'h0, 0, 2);
        tx("ld_w7fe", 32'h7FE, 32'h0,        SZ_W, 0, 0, 32'h0, 1, 1);
        tx("st_w7fd", 32'h7FD, 32'hDEADBEEF, SZ_W, 1, 0, 32'h0, 1, 1);
        tx("st_x10",  32'h10,  32'hFFFFFFFF, SZ_X, 1, 0, 32'h0, 1, 1);
        tx("ld_x10",  32'h10,  32'h0,        SZ_X, 0, 0, 32'h0, 1, 1);
        tx("st_b800", 32'h800, 32'h000000EE, SZ_B, 1, 0, 32'h0, 1, 1);
        tx("st_h7ff", 32'h7FF, 32'h0000EEEE, SZ_H, 1, 0, 32'h0, 1, 1);
        tx("ld_bu7ff",32'h7FF, 32'h0,        SZ_B, 0, 0, 32'h00000001, 0, 2);
        tx("ld_w7fc", 32'h7FC, 32'h0,        SZ_W, 0, 0, 32'h01020304, 0, 2);
        tx("ld_w10b", 32'h10,  32'h0,        SZ_W, 0, 0, 32'h11225A44, 0, 2);

        // Response back-pressure with a second request already waiting
        i_rsp_ready = 1'b0;
        begin
            logic [31:0] rd;
            logic        er;
            int          lat;
            send(32'h10, 32'h0, SZ_W, 0, 0, rd, er, lat);
            chk("hold.first", rd, 32'h11225A44);
            held = rd;
        end
        i_req_valid  = 1'b1;
        i_req_addr   = 32'h20;
        i_req_size   = SZ_W;
        i_req_wren   = 1'b0;
        i_req_signed = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            chk("hold.valid", {31'd0, o_rsp_valid}, 32'd1);
            chk("hold.rdata", o_rsp_rdata, held);
            chk("hold.err",   {31'd0, o_rsp_err}, 32'd0);
            chk("hold.ready", {31'd0, o_req_ready}, 32'd0);
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("b2b.idle_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("b2b.idle_ready", {31'd0, o_req_ready}, 32'd1);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        chk("b2b.acc_ready", {31'd0, o_req_ready}, 32'd0);
        chk("b2b.acc_valid", {31'd0, o_rsp_valid}, 32'd0);
        @(posedge i_clk); #1;
        chk("b2b.valid", {31'd0, o_rsp_valid}, 32'd1);
        chk("b2b.rdata", o_rsp_rdata, 32'hBBCCDD88);
        @(posedge i_clk); #1;
        chk("b2b.single_rsp", {31'd0, o_rsp_valid}, 32'd0);
        chk("b2b.ready_again", {31'd0, o_req_ready}, 32'd1);

        // Reset during ACC1 of a spanning store
        tx("pre_w40", 32'h40, 32'h00000000, SZ_W, 1, 0, 32'h0, 0, 2);
        tx("pre_w44", 32'h44, 32'h12345678, SZ_W, 1, 0, 32'h0, 0, 2);
        i_req_valid  = 1'b1;
        i_req_addr   = 32'h42;
        i_req_wdata  = 32'hCAFEF00D;
        i_req_size   = SZ_W;
        i_req_wren   = 1'b1;
        i_req_signed = 1'b0;
        for (int n = 0; n < 20 && !o_req_ready; n++) begin
            @(posedge i_clk); #1;
        end
        @(posedge i_clk); #1;           // accepted, now in ACC0
        i_req_valid = 1'b0;
        @(posedge i_clk); #1;           // word W written, now in ACC1
        i_reset_n = 1'b0;
        #1;
        chk("midrst.valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("midrst.ready", {31'd0, o_req_ready}, 32'd1);
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("midrst.no_rsp", {31'd0, o_rsp_valid}, 32'd0);
        chk("midrst.ready_after", {31'd0, o_req_ready}, 32'd1);
        tx("ld_w40", 32'h40, 32'h0, SZ_W, 0, 0, 32'hF00D0000, 0, 2);
        tx("ld_w44", 32'h44, 32'h0, SZ_W, 0, 0, 32'h12345678, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
